freelist_ckpt_ctrl: RTL and testbench

- Branch-checkpoint controller for the physical-register freelist.
- Takes a snapshot of freelist availability when each branch dispatches, and keeps every live snapshot current with retire-time frees.
- On a branch mispredict, drives the freelist's mispredict/restore_mask pair from the correct snapshot.
- Sits between dispatch/branch-resolve and the freelist's mispredict/restore_mask inputs.

---
 rtl/freelist_ckpt_ctrl.sv | 134 +++++++++++++
 tb/tb_freelist_ckpt_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freelist_ckpt_ctrl.sv
// Branch-checkpoint controller for the physical-register freelist: snapshots
// availability per branch, keeps snapshots current with frees, restores on mispredict.
module freelist_ckpt_ctrl #(
  parameter int unsigned ALLOC_WIDTH = 2,
  parameter int unsigned PR_COUNT    = 64,
  parameter int unsigned CKPT_COUNT  = 4,
  parameter int unsigned CKPT_IDX_W  = $clog2(CKPT_COUNT),
  parameter int unsigned LANE_W      = (ALLOC_WIDTH > 1) ? $clog2(ALLOC_WIDTH) : 1
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [PR_COUNT-1:0]                       avail_regs,
  input  logic [ALLOC_WIDTH-1:0]                    alloc_req,
  input  logic [ALLOC_WIDTH-1:0][PR_COUNT-1:0]      granted_regs,
  input  logic [PR_COUNT-1:0]                       free_mask,
  input  logic                                      ckpt_req,
  input  logic [LANE_W-1:0]                         ckpt_lane,
  output logic                                      ckpt_grant,
  output logic [CKPT_IDX_W-1:0]                     ckpt_id,
  output logic                                      ckpt_full,
  input  logic                                      resolve_valid,
  input  logic [CKPT_IDX_W-1:0]                     resolve_id,
  input  logic                                      resolve_mispredict,
  output logic                                      mispredict_out,
  output logic [PR_COUNT-1:0]                       restore_mask,
  output logic [$clog2(PR_COUNT+1)-1:0]             restore_count,
  output logic [$clog2(CKPT_COUNT+1)-1:0]           live_count
);

  localparam int unsigned PTR_W = CKPT_IDX_W + 1;
  localparam int unsigned RC_W  = $clog2(PR_COUNT+1);
  localparam int unsigned LC_W  = $clog2(CKPT_COUNT+1);

  logic [CKPT_COUNT-1:0][PR_COUNT-1:0] snap_q, snap_d;
  logic [CKPT_COUNT-1:0]               valid_q, valid_d;
  logic [PTR_W-1:0]                    head_q, head_d, tail_q, tail_d;
  logic                                pending_mp_q, pending_mp_d;
  logic [CKPT_IDX_W-1:0]               pending_id_q, pending_id_d;

  logic [PR_COUNT-1:0]   taken, snapshot;
  logic [31:0]           lane_ext;
  logic [PTR_W-1:0]      occupancy, mp_tail, squash_len;
  logic [CKPT_IDX_W-1:0] mp_dist, slot_dist;
  logic                  mp_req, mp_fire, cr_fire;

  assign lane_ext = 32'(ckpt_lane);

  // Registers granted to the branch lane and older lanes are already consumed.
  always_comb begin
    taken = '0;
    for (int unsigned l = 0; l < ALLOC_WIDTH; l++) begin
      if (l <= lane_ext && alloc_req[l]) taken = taken | granted_regs[l];
    end
  end
  assign snapshot = avail_regs & ~taken;

  assign occupancy  = tail_q - head_q;
  assign ckpt_full  = (occupancy == PTR_W'(CKPT_COUNT));
  assign mp_req     = resolve_valid & resolve_mispredict;
  assign ckpt_grant = ckpt_req & ~ckpt_full & ~pending_mp_q & ~mp_req;
  assign ckpt_id    = tail_q[CKPT_IDX_W-1:0];
  assign mp_fire    = mp_req & valid_q[resolve_id] & ~pending_mp_q;
  assign cr_fire    = resolve_valid & ~resolve_mispredict & valid_q[resolve_id];

  // Rebuild the pointer for resolve_id from head so the wrap bit stays consistent.
  assign mp_dist    = resolve_id - head_q[CKPT_IDX_W-1:0];
  assign mp_tail    = head_q + {1'b0, mp_dist};
  assign squash_len = tail_q - mp_tail;

  always_comb begin
    snap_d       = '0;
    valid_d      = valid_q;
    tail_d       = tail_q;
    head_d       = head_q;
    slot_dist    = '0;
    pending_mp_d = mp_fire;
    pending_id_d = mp_fire ? resolve_id : pending_id_q;

    for (int unsigned i = 0; i < CKPT_COUNT; i++) snap_d[i] = snap_q[i] | free_mask;

    if (head_q != tail_q && !valid_q[head_q[CKPT_IDX_W-1:0]]) head_d = head_q + 1'b1;

    if (cr_fire) valid_d[resolve_id] = 1'b0;

    if (ckpt_grant) begin
      snap_d[tail_q[CKPT_IDX_W-1:0]]  = snapshot | free_mask;
      valid_d[tail_q[CKPT_IDX_W-1:0]] = 1'b1;
      tail_d                          = tail_q + 1'b1;
    end

    // Squash the mispredicted branch and everything younger, in circular order.
    if (mp_fire) begin
      tail_d = mp_tail;
      for (int unsigned i = 0; i < CKPT_COUNT; i++) begin
        slot_dist = CKPT_IDX_W'(i) - resolve_id;
        if ({1'b0, slot_dist} < squash_len) valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      pending_mp_q <= 1'b0;
      pending_id_q <= '0;
    end else begin
      valid_q      <= valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      pending_mp_q <= pending_mp_d;
      pending_id_q <= pending_id_d;
    end
  end

  always_ff @(posedge clock) begin
    snap_q <= snap_d;
  end

  assign mispredict_out = pending_mp_q;
  assign restore_mask   = pending_mp_q ? (snap_q[pending_id_q] | free_mask) : '0;

  always_comb begin
    restore_count = '0;
    for (int unsigned i = 0; i < PR_COUNT; i++) restore_count = restore_count + RC_W'(restore_mask[i]);
  end

  always_comb begin
    live_count = '0;
    for (int unsigned i = 0; i < CKPT_COUNT; i++) live_count = live_count + LC_W'(valid_q[i]);
  end

endmodule

// File: tb/tb_freelist_ckpt_ctrl.sv
// Directed bench for freelist_ckpt_ctrl; restore results are checked against
// a queue of expectations pushed when each mispredict resolve is driven.
module tb_freelist_ckpt_ctrl;

  localparam int unsigned AW = 2;
  localparam int unsigned PR = 64;
  localparam int unsigned CK = 4;
  localparam int unsigned IW = 2;

  logic                 clock;
  logic                 reset;
  logic [PR-1:0]        avail_regs;
  logic [AW-1:0]        alloc_req;
  logic [AW-1:0][PR-1:0] granted_regs;
  logic [PR-1:0]        free_mask;
  logic                 ckpt_req;
  logic [0:0]           ckpt_lane;
  logic                 ckpt_grant;
  logic [IW-1:0]        ckpt_id;
  logic                 ckpt_full;
  logic                 resolve_valid;
  logic [IW-1:0]        resolve_id;
  logic                 resolve_mispredict;
  logic                 mispredict_out;
  logic [PR-1:0]        restore_mask;
  logic [6:0]           restore_count;
  logic [2:0]           live_count;

  freelist_ckpt_ctrl #(
    .ALLOC_WIDTH (AW),
    .PR_COUNT    (PR),
    .CKPT_COUNT  (CK)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .avail_regs         (avail_regs),
    .alloc_req          (alloc_req),
    .granted_regs       (granted_regs),
    .free_mask          (free_mask),
    .ckpt_req           (ckpt_req),
    .ckpt_lane          (ckpt_lane),
    .ckpt_grant         (ckpt_grant),
    .ckpt_id            (ckpt_id),
    .ckpt_full          (ckpt_full),
    .resolve_valid      (resolve_valid),
    .resolve_id         (resolve_id),
    .resolve_mispredict (resolve_mispredict),
    .mispredict_out     (mispredict_out),
    .restore_mask       (restore_mask),
    .restore_count      (restore_count),
    .live_count         (live_count)
  );

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;
  logic [63:0] exp_mask_q [$];
  logic [63:0] exp_cnt_q  [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push_restore(input logic [63:0] mask, input logic [63:0] cnt);
    exp_mask_q.push_back(mask);
    exp_cnt_q.push_back(cnt);
    pushes++;
  endtask

  // Each restore pulse consumes one expectation; a pulse with none queued fails.
  always @(negedge clock) begin
    if (mispredict_out === 1'b1) begin
      if (exp_mask_q.size() == 0) begin
        check("unexpected_restore", 64'(mispredict_out), 64'd0);
      end else begin
        logic [63:0] m;
        logic [63:0] c;
        m = exp_mask_q.pop_front();
        c = exp_cnt_q.pop_front();
        pops++;
        check("restore_mask", restore_mask, m);
        check("restore_count", 64'(restore_count), c);
      end
    end
  end

  initial begin
    logic [63:0] av [3];
    av[0] = 64'h0AAA;
    av[1] = 64'h1111;
    av[2] = 64'h2222;

    reset = 1'b1; avail_regs = '0; alloc_req = '0; granted_regs = '0; free_mask = '0;
    ckpt_req = 1'b0; ckpt_lane = '0; resolve_valid = 1'b0; resolve_id = '0;
    resolve_mispredict = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    #1;
    check("rst_full", 64'(ckpt_full), 64'd0);
    check("rst_mp_out", 64'(mispredict_out), 64'd0);
    check("rst_restore_mask", restore_mask, 64'd0);
    check("rst_live", 64'(live_count), 64'd0);
    check("rst_grant", 64'(ckpt_grant), 64'd0);

    // Lane-0 branch: lane-1 grant is younger and must come back free.
    cyc();
    avail_regs = 64'hFFFF_FFFF_0000_0000; alloc_req = 2'b11;
    granted_regs[0] = 64'h1 << 32; granted_regs[1] = 64'h1 << 33;
    ckpt_req = 1'b1; ckpt_lane = 1'b0;
    #1;
    check("t2_grant", 64'(ckpt_grant), 64'd1);
    check("t2_id", 64'(ckpt_id), 64'd0);
    cyc();
    alloc_req = '0; granted_regs = '0;
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd0;
    push_restore(64'hFFFF_FFFE_0000_0000, 64'd31);
    #1;
    check("t2_live_before", 64'(live_count), 64'd1);
    check("t2_grant_in_resolve", 64'(ckpt_grant), 64'd0);
    cyc();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0; ckpt_req = 1'b0;
    #1;
    check("t2_mp_out", 64'(mispredict_out), 64'd1);
    check("t2_live_after", 64'(live_count), 64'd0);
    cyc();
    #1;
    check("t2_mp_out_clear", 64'(mispredict_out), 64'd0);
    check("t2_mask_clear", restore_mask, 64'd0);

    // Frees after the snapshot and in the restore cycle both land in the mask.
    avail_regs = 64'h0F00; ckpt_req = 1'b1;
    #1;
    check("t3_grant", 64'(ckpt_grant), 64'd1);
    check("t3_id", 64'(ckpt_id), 64'd0);
    cyc();
    ckpt_req = 1'b0; free_mask = 64'h20;
    cyc();
    free_mask = '0;
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd0;
    push_restore(64'h0F60, 64'd6);
    cyc();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0; free_mask = 64'h40;
    #1;
    check("t3_mp_out", 64'(mispredict_out), 64'd1);
    cyc();
    free_mask = '0;

    // Fill all slots, release the oldest, and wrap the tag.
    for (int i = 0; i < 4; i++) begin
      ckpt_req = 1'b1; avail_regs = 64'(i + 1);
      #1;
      check("t4_fill_grant", 64'(ckpt_grant), 64'd1);
      check("t4_fill_id", 64'(ckpt_id), 64'(i));
      cyc();
    end
    ckpt_req = 1'b1;
    #1;
    check("t4_full", 64'(ckpt_full), 64'd1);
    check("t4_live_full", 64'(live_count), 64'd4);
    check("t4_grant_when_full", 64'(ckpt_grant), 64'd0);
    ckpt_req = 1'b0;
    resolve_valid = 1'b1; resolve_mispredict = 1'b0; resolve_id = 2'd0;
    cyc();
    resolve_valid = 1'b0;
    cyc();
    #1;
    check("t4_full_released", 64'(ckpt_full), 64'd0);
    check("t4_live_released", 64'(live_count), 64'd3);
    ckpt_req = 1'b1;
    #1;
    check("t4_wrap_grant", 64'(ckpt_grant), 64'd1);
    check("t4_wrap_id", 64'(ckpt_id), 64'd0);
    cyc();
    ckpt_req = 1'b0;
    #1;
    check("t4_full_again", 64'(ckpt_full), 64'd1);

    // Mispredict a middle checkpoint; younger ones are squashed.
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ckpt_req = 1'b1; avail_regs = av[i];
      #1;
      check("t5_grant", 64'(ckpt_grant), 64'd1);
      check("t5_id", 64'(ckpt_id), 64'(i));
      cyc();
    end
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd1;
    ckpt_req = 1'b1;
    push_restore(64'h1111, 64'd4);
    #1;
    check("t5_grant_resolve_cycle", 64'(ckpt_grant), 64'd0);
    check("t5_live_before", 64'(live_count), 64'd3);
    cyc();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0; ckpt_req = 1'b1;
    #1;
    check("t5_grant_restore_cycle", 64'(ckpt_grant), 64'd0);
    check("t5_mp_out", 64'(mispredict_out), 64'd1);
    check("t5_live_after", 64'(live_count), 64'd1);
    cyc();
    ckpt_req = 1'b1; avail_regs = 64'h3333;
    #1;
    check("t5_regrant", 64'(ckpt_grant), 64'd1);
    check("t5_regrant_id", 64'(ckpt_id), 64'd1);
    check("t5_mp_out_clear", 64'(mispredict_out), 64'd0);
    cyc();
    ckpt_req = 1'b0;
    #1;
    check("t5_live_regrant", 64'(live_count), 64'd2);

    // Reset asserted during the restore cycle.
    ckpt_req = 1'b1; avail_regs = 64'h2222;
    #1;
    check("t6_id", 64'(ckpt_id), 64'd2);
    cyc();
    ckpt_req = 1'b0;
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd2;
    push_restore(64'h2222, 64'd4);
    cyc();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0; reset = 1'b1;
    #1;
    check("t6_mp_out", 64'(mispredict_out), 64'd1);
    cyc();
    #1;
    check("t6_mp_out_reset", 64'(mispredict_out), 64'd0);
    check("t6_live_reset", 64'(live_count), 64'd0);
    check("t6_full_reset", 64'(ckpt_full), 64'd0);
    reset = 1'b0;
    cyc(); cyc();

    check("scoreboard_drained", 64'(exp_mask_q.size()), 64'd0);
    check("restore_pulses", 64'(pops), 64'(pushes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
